iq_credit_ctrl: RTL and testbench
=================================

Name: iq_credit_ctrl

Overview:
Credit-based flow controller for the four issue queues fed by the dispatch stage: alu0, alu1, mdu and lsu. It keeps one free-entry counter per queue and drives a registered per-queue ready. Dispatch ANDs these readies into its upstream ready. The block decrements credits on dispatch fire, increments them when a queue issues, and runs a post-flush drain sequence before dispatch may resume.

Parameters:
ALU_DEPTH, 8, entries in each ALU issue queue (alu0 and alu1).
MDU_DEPTH, 4, entries in the MDU issue queue.
LSU_DEPTH, 8, entries in the LSU issue queue.
DRAIN_CYC, 2, cycles ready is held low after a flush or reset; must be >= 1.
CW, $clog2(max depth + 1), width of each credit counter (derived, not overridable).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
flush_i  in  1  pipeline flush; all issue queues are emptied this cycle.
fire_i  in  1  dispatch handshake completed this cycle.
req_cnt_i  in  4x2  per-queue entries consumed on fire, 0..2; index [0]=alu0, [1]=alu1, [2]=mdu, [3]=lsu.
rel_i  in  4  per-queue: one entry issued and freed this cycle.
ready_o  out  4  per-queue: at least 2 free entries, state RUN.
all_ready_o  out  1  AND of ready_o.
credit_o  out  4xCW  current credit counters.
err_o  out  1  sticky protocol-error flag.

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst; there is a single clock domain.
- Reset values:
  - credits = depth (alu0 = alu1 = ALU_DEPTH, mdu = MDU_DEPTH, lsu = LSU_DEPTH).
  - state = DRAIN, drain counter = DRAIN_CYC-1.
  - ready_o = 0, err_o = 0.
- FSM with two states, RUN and DRAIN:
  - RUN -> DRAIN on flush_i: credits reload to depth, drain counter loads DRAIN_CYC-1.
  - DRAIN -> RUN when the drain counter is 0 and flush_i = 0. Otherwise the counter decrements.
  - flush_i in DRAIN reloads the counter.
- Credit update in RUN, when flush_i = 0, per queue k:
  - next = credit - (fire_i ? req_cnt_i[k] : 0) + rel_i[k].
  - Computed in CW+1 bits.
  - Fire and release in the same cycle are both applied.
- Underflow: subtracted amount > credit + rel_i[k]. The result saturates at 0 and err_o is set.
- Overflow: result > depth. The result saturates at depth and err_o is set.
- In DRAIN, rel_i is ignored because queues are empty and credits are already full.
  - fire_i = 1 with any non-zero req_cnt_i in DRAIN sets err_o; credits are unchanged.
- flush_i has priority over fire_i and rel_i in the same cycle. Credits become depth, with no error checks that cycle.
- Ready generation:
  - ready_o[k] is registered: ready_o[k] <= (next_state == RUN) && (next_credit[k] >= 2).
  - The ready visible in cycle n therefore always matches credit_o in cycle n, with no combinational path from the req/rel inputs.
  - The threshold of 2 is fixed because dispatch can send 2 instructions to one queue in a cycle.
  - Ready does not depend on req_cnt_i.
- all_ready_o is combinational &ready_o.
- credit_o is a direct view of the counter registers.
- err_o is sticky; it is cleared only by rst.
- Latency from a credit change to ready_o is 1 cycle.
- Latency from flush_i to ready_o high is DRAIN_CYC+1 cycles, i.e. the first RUN cycle.

Test Plan:
1. Defaults, rst high 2 cycles then low:
   - ready_o = 4'b0000 for 2 cycles, then 4'b1111.
   - credit_o = {8,4,8,8} as lsu, mdu, alu1, alu0.
   - err_o = 0.
2. In RUN, fire_i with req_cnt_i[2] = 2 for 2 consecutive cycles, rel_i = 0:
   - mdu credit goes 4 -> 2 -> 0, and ready_o[2] = 1, 1, 0.
   - Then rel_i[2] pulses on two cycles: credit 1 with ready 0, then credit 2 with ready 1.
3. alu0 credit at 3, then fire_i with req_cnt_i[0] = 2 and rel_i[0] = 1 in the same cycle:
   - credit becomes 2, ready_o[0] stays 1, err_o = 0.
4. Credits {0,1,5,3}, then flush_i together with fire_i and rel_i = 4'b1111:
   - Next cycle credits {8,4,8,8}, ready_o = 0.
   - rel_i pulses during DRAIN are ignored.
   - ready_o = 4'b1111 in the 3rd cycle after the flush.
5. Error cases:
   - lsu credit 0, then fire_i with req_cnt_i[3] = 2: err_o = 1, credit stays 0.
   - Separately, rel_i[1] with alu1 full: err_o = 1, credit stays 8.
   - err_o stays 1 through a flush and clears only on rst.
6. During DRAIN, fire_i with req_cnt_i = {1,0,0,0}: err_o = 1, credit_o unchanged, state still exits DRAIN on schedule.

Source files
------------

// File: rtl/iq_credit_ctrl.sv
// Credit-based flow control for the four dispatch-fed issue queues (alu0, alu1, mdu, lsu).
// One free-entry counter per queue, a registered per-queue ready and a post-flush drain
// window that must expire before dispatch may resume.
module iq_credit_ctrl #(
  parameter int unsigned ALU_DEPTH = 8,
  parameter int unsigned MDU_DEPTH = 4,
  parameter int unsigned LSU_DEPTH = 8,
  parameter int unsigned DRAIN_CYC = 2,
  localparam int unsigned MAX_DEPTH =
    (ALU_DEPTH > MDU_DEPTH) ? ((ALU_DEPTH > LSU_DEPTH) ? ALU_DEPTH : LSU_DEPTH)
                            : ((MDU_DEPTH > LSU_DEPTH) ? MDU_DEPTH : LSU_DEPTH),
  localparam int unsigned CW = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 fire_i,
  input  logic [3:0][1:0]      req_cnt_i,
  input  logic [3:0]           rel_i,
  output logic [3:0]           ready_o,
  output logic                 all_ready_o,
  output logic [3:0][CW-1:0]   credit_o,
  output logic                 err_o
);

  localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LD = DCW'(DRAIN_CYC - 1);
  // Per-queue capacity, index order matches req_cnt_i / rel_i.
  localparam logic [3:0][CW-1:0] DEPTH_VEC = {CW'(LSU_DEPTH), CW'(MDU_DEPTH),
                                              CW'(ALU_DEPTH), CW'(ALU_DEPTH)};

  typedef enum logic {StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic [3:0][CW-1:0]   credit_q, credit_d;
  logic [3:0]           ready_q, ready_d;
  logic                 err_q, err_d;

  // Per-queue arithmetic in CW+1 bits so neither direction wraps.
  logic [3:0][CW:0]     avail;
  logic [3:0][CW:0]     take;
  logic [3:0][CW:0]     diff;
  logic [3:0]           under;
  logic [3:0]           over;

  // Saturating credit arithmetic and out-of-range detection for each queue.
  always_comb begin
    avail = '0;
    take  = '0;
    diff  = '0;
    under = '0;
    over  = '0;
    for (int k = 0; k < 4; k++) begin
      avail[k] = {1'b0, credit_q[k]} + (CW+1)'(rel_i[k]);
      take[k]  = fire_i ? (CW+1)'(req_cnt_i[k]) : '0;
      under[k] = take[k] > avail[k];
      diff[k]  = avail[k] - take[k];
      over[k]  = !under[k] && (diff[k] > {1'b0, DEPTH_VEC[k]});
    end
  end

  // Next-state, credit, error and ready computation; flush wins over everything.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    credit_d = credit_q;
    err_d    = err_q;
    ready_d  = '0;
    unique case (state_q)
      StRun: begin
        if (flush_i) begin
          state_d  = StDrain;
          drain_d  = DRAIN_LD;
          credit_d = DEPTH_VEC;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (under[k]) begin
              credit_d[k] = '0;
              err_d       = 1'b1;
            end else if (over[k]) begin
              credit_d[k] = DEPTH_VEC[k];
              err_d       = 1'b1;
            end else begin
              credit_d[k] = diff[k][CW-1:0];
            end
          end
        end
      end
      StDrain: begin
        if (flush_i) begin
          drain_d  = DRAIN_LD;
          credit_d = DEPTH_VEC;
        end else begin
          // Queues are empty here, so releases are meaningless and dispatch must not fire.
          if (fire_i && (|req_cnt_i)) err_d = 1'b1;
          if (drain_q == '0) begin
            state_d = StRun;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = StDrain;
        drain_d = DRAIN_LD;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      ready_d[k] = (state_d == StRun) && (credit_d[k] >= CW'(2));
    end
  end

  // State, counters and registered readies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StDrain;
      drain_q  <= DRAIN_LD;
      credit_q <= DEPTH_VEC;
      ready_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      credit_q <= credit_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign ready_o     = ready_q;
  assign all_ready_o = &ready_q;
  assign credit_o    = credit_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_iq_credit_ctrl.sv
// Directed bench for iq_credit_ctrl with default parameters (depths 8/8/4/8, drain 2).
// Credits are compared as a packed 16-bit word {lsu, mdu, alu1, alu0}.
module tb_iq_credit_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            fire_i;
  logic [3:0][1:0] req_cnt_i;
  logic [3:0]      rel_i;
  logic [3:0]      ready_o;
  logic            all_ready_o;
  logic [3:0][3:0] credit_o;
  logic            err_o;

  int checks = 0;
  int errors = 0;

  iq_credit_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .fire_i      (fire_i),
    .req_cnt_i   (req_cnt_i),
    .rel_i       (rel_i),
    .ready_o     (ready_o),
    .all_ready_o (all_ready_o),
    .credit_o    (credit_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i   = 1'b0;
    fire_i    = 1'b0;
    req_cnt_i = '0;
    rel_i     = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // 1. Reset defaults and drain exit.
    tick();
    tick();
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_credit", 32'(credit_o), 32'h8488);
    check("rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;
    tick();
    check("drain_ready", 32'(ready_o), 32'h0);
    tick();
    check("run_ready", 32'(ready_o), 32'hf);
    check("run_all_ready", 32'(all_ready_o), 32'h1);

    // 2. mdu drained by two double fires, then refilled by two releases.
    fire_i = 1'b1;
    req_cnt_i[2] = 2'd2;
    tick();
    check("mdu_c2", 32'(credit_o), 32'h8288);
    check("mdu_r2", 32'(ready_o), 32'hf);
    tick();
    check("mdu_c0", 32'(credit_o), 32'h8088);
    check("mdu_r0", 32'(ready_o), 32'hb);
    check("mdu_all0", 32'(all_ready_o), 32'h0);
    idle();
    rel_i[2] = 1'b1;
    tick();
    check("mdu_c1", 32'(credit_o), 32'h8188);
    check("mdu_r1", 32'(ready_o), 32'hb);
    tick();
    check("mdu_c2b", 32'(credit_o), 32'h8288);
    check("mdu_r2b", 32'(ready_o), 32'hf);
    idle();

    // Bring credits to {lsu 0, mdu 1, alu1 5, alu0 3}.
    fire_i = 1'b1;
    req_cnt_i = {2'd2, 2'd1, 2'd2, 2'd2};
    tick();
    check("mix_a", 32'(credit_o), 32'h6166);
    req_cnt_i = {2'd2, 2'd0, 2'd1, 2'd2};
    tick();
    check("mix_b", 32'(credit_o), 32'h4154);
    req_cnt_i = {2'd2, 2'd0, 2'd0, 2'd1};
    tick();
    check("mix_c", 32'(credit_o), 32'h2153);
    req_cnt_i = {2'd2, 2'd0, 2'd0, 2'd0};
    tick();
    check("mix_d", 32'(credit_o), 32'h0153);
    check("mix_ready", 32'(ready_o), 32'h3);

    // 3. alu0 at 3: fire of 2 with a simultaneous release lands on 2.
    req_cnt_i = {2'd0, 2'd0, 2'd0, 2'd2};
    rel_i = 4'b0001;
    tick();
    check("both_credit", 32'(credit_o), 32'h0152);
    check("both_ready", 32'(ready_o), 32'h3);
    check("both_err", 32'(err_o), 32'h0);
    idle();
    rel_i = 4'b0001;
    tick();
    check("pre_flush", 32'(credit_o), 32'h0153);
    idle();

    // 4. Flush beats a simultaneous fire and release; drain ignores releases.
    flush_i = 1'b1;
    fire_i = 1'b1;
    req_cnt_i = {2'd2, 2'd2, 2'd2, 2'd2};
    rel_i = 4'b1111;
    tick();
    check("flush_credit", 32'(credit_o), 32'h8488);
    check("flush_ready", 32'(ready_o), 32'h0);
    check("flush_err", 32'(err_o), 32'h0);
    idle();
    rel_i = 4'b1111;
    tick();
    check("drain_rel_credit", 32'(credit_o), 32'h8488);
    check("drain_rel_ready", 32'(ready_o), 32'h0);
    check("drain_rel_err", 32'(err_o), 32'h0);
    idle();
    tick();
    check("flush_exit_ready", 32'(ready_o), 32'hf);

    // 5a. lsu underflow saturates at 0 and latches the error.
    fire_i = 1'b1;
    req_cnt_i = {2'd2, 2'd0, 2'd0, 2'd0};
    repeat (4) tick();
    check("lsu_empty", 32'(credit_o), 32'h0488);
    check("lsu_noerr", 32'(err_o), 32'h0);
    tick();
    check("under_credit", 32'(credit_o), 32'h0488);
    check("under_err", 32'(err_o), 32'h1);
    idle();

    // 5b. After reset, a release into a full alu1 saturates and errors.
    rst = 1'b1;
    tick();
    check("rst_clears_err", 32'(err_o), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check("rerun_ready", 32'(ready_o), 32'hf);
    rel_i = 4'b0010;
    tick();
    check("over_credit", 32'(credit_o), 32'h8488);
    check("over_err", 32'(err_o), 32'h1);
    idle();
    flush_i = 1'b1;
    tick();
    idle();
    check("err_sticky_flush", 32'(err_o), 32'h1);
    tick();
    tick();
    check("err_sticky_run", 32'(err_o), 32'h1);
    rst = 1'b1;
    tick();
    check("err_cleared", 32'(err_o), 32'h0);

    // 6. Fire during drain errors, leaves credits alone, does not delay exit.
    rst = 1'b0;
    fire_i = 1'b1;
    req_cnt_i = {2'd1, 2'd0, 2'd0, 2'd0};
    tick();
    check("drain_fire_err", 32'(err_o), 32'h1);
    check("drain_fire_credit", 32'(credit_o), 32'h8488);
    check("drain_fire_ready", 32'(ready_o), 32'h0);
    idle();
    tick();
    check("drain_fire_exit", 32'(ready_o), 32'hf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
